// File: rtl/score_text_rom_pkg.sv
// Shared constants for the score text ROM: ASCII codes, status modes and
// the conversion FSM state encoding.
package score_text_rom_pkg;

  localparam int unsigned CHAR_W = 7;
  localparam int unsigned BCD_W  = 16;

  localparam logic [6:0] ASCII_BLANK = 7'h20;
  localparam logic [6:0] ASCII_COLON = 7'h3A;
  localparam logic [6:0] ASCII_0     = 7'h30;

  localparam logic [6:0] CAP_A = 7'h41, CAP_B = 7'h42, CAP_C = 7'h43, CAP_D = 7'h44;
  localparam logic [6:0] CAP_E = 7'h45, CAP_F = 7'h46, CAP_G = 7'h47, CAP_H = 7'h48;
  localparam logic [6:0] CAP_I = 7'h49, CAP_J = 7'h4A, CAP_K = 7'h4B, CAP_L = 7'h4C;
  localparam logic [6:0] CAP_M = 7'h4D, CAP_N = 7'h4E, CAP_O = 7'h4F, CAP_P = 7'h50;
  localparam logic [6:0] CAP_Q = 7'h51, CAP_R = 7'h52, CAP_S = 7'h53, CAP_T = 7'h54;
  localparam logic [6:0] CAP_U = 7'h55, CAP_V = 7'h56, CAP_W = 7'h57, CAP_X = 7'h58;
  localparam logic [6:0] CAP_Y = 7'h59, CAP_Z = 7'h5A;

  typedef enum logic [1:0] {
    MODE_NONE        = 2'd0,
    MODE_PAUSED      = 2'd1,
    MODE_GAME_OVER   = 2'd2,
    MODE_PRESS_START = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_NEXT   = 3'd3,
    ST_LOAD_B = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  function automatic logic [6:0] digit_char(input logic [3:0] d);
    return ASCII_0 + 7'(d);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter, one bit per cycle.
module bin2bcd_seq
  import score_text_rom_pkg::*;
#(
  parameter int unsigned SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic [SCORE_W-1:0] i_bin,
  output logic               o_busy,
  output logic               o_done_c,
  output logic [BCD_W-1:0]   o_bcd
);

  localparam int unsigned CNT_W = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] r_shift;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [BCD_W-1:0]   w_adj;

  // Pre-shift correction: any nibble of 5 or more gets 3 added.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_shift <= i_bin;
      r_bcd   <= '0;
      r_cnt   <= CNT_W'(SCORE_W);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_bcd   <= BCD_W'({w_adj, r_shift[SCORE_W-1]});
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy   = r_busy;
  assign o_done_c = r_busy && (r_cnt == CNT_W'(1));
  assign o_bcd    = r_bcd;

endmodule

// File: rtl/score_text_rom.sv
// Character ROM for the score overlay: two score lines, a blinking status
// line, and a per-frame BCD conversion of both scores.
module score_text_rom
  import score_text_rom_pkg::*;
#(
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned BLANK_LEAD   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic [SCORE_W-1:0] score_red,
  input  logic [SCORE_W-1:0] score_blue,
  input  logic [1:0]         mode,
  input  logic               blink_en,
  input  logic [7:0]         char_xy,
  output logic [6:0]         char_code,
  output logic               busy
);

  state_e             r_state, w_next;
  logic               r_busy;
  logic [SCORE_W-1:0] r_shadow_red, r_shadow_blue;
  logic               r_sel_blue;
  logic [BCD_W-1:0]   r_bcd_red, r_disp_red, r_disp_blue;
  logic [7:0]         r_blink_cnt;
  logic               r_phase;
  logic [6:0]         r_char;

  logic               w_accept_c, w_start_c, w_store_red_c, w_commit_c;
  logic               w_eng_busy, w_eng_done_c;
  logic [BCD_W-1:0]   w_eng_bcd;
  logic [6:0]         w_char;
  logic [3:0]         w_line, w_col;

  bin2bcd_seq #(.SCORE_W(SCORE_W)) u_bin2bcd (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_start_c),
    .i_bin    (r_sel_blue ? r_shadow_blue : r_shadow_red),
    .o_busy   (w_eng_busy),
    .o_done_c (w_eng_done_c),
    .o_bcd    (w_eng_bcd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
    end
  end

  always_comb begin
    w_next        = r_state;
    w_accept_c    = 1'b0;
    w_start_c     = 1'b0;
    w_store_red_c = 1'b0;
    w_commit_c    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_tick) begin
          w_accept_c = 1'b1;
          w_next     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_start_c = 1'b1;
        w_next    = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_eng_done_c || !w_eng_busy) w_next = r_sel_blue ? ST_COMMIT : ST_NEXT;
      end
      ST_NEXT: begin
        w_store_red_c = 1'b1;
        w_next        = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        w_start_c = 1'b1;
        w_next    = ST_SHIFT;
      end
      ST_COMMIT: begin
        w_commit_c = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Blue's result is taken straight from the engine at commit time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow_red  <= '0;
      r_shadow_blue <= '0;
      r_sel_blue    <= 1'b0;
      r_bcd_red     <= '0;
      r_disp_red    <= '0;
      r_disp_blue   <= '0;
    end else begin
      if (w_accept_c) begin
        r_shadow_red  <= score_red;
        r_shadow_blue <= score_blue;
        r_sel_blue    <= 1'b0;
      end
      if (w_store_red_c) begin
        r_bcd_red  <= w_eng_bcd;
        r_sel_blue <= 1'b1;
      end
      if (w_commit_c) begin
        r_disp_red  <= r_bcd_red;
        r_disp_blue <= w_eng_bcd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (frame_tick) begin
      if (r_blink_cnt == 8'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  function automatic logic [6:0] red_text(input logic [3:0] c);
    case (c)
      4'd0: return CAP_R;  4'd1: return CAP_E;  4'd2: return CAP_D;
      4'd4: return CAP_P;  4'd5: return CAP_L;  4'd6: return CAP_A;
      4'd7: return CAP_Y;  4'd8: return CAP_E;  4'd9: return CAP_R;
      default: return ASCII_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] blue_text(input logic [3:0] c);
    case (c)
      4'd0: return CAP_B;  4'd1: return CAP_L;  4'd2: return CAP_U;
      4'd3: return CAP_E;  4'd5: return CAP_P;  4'd6: return CAP_L;
      4'd7: return CAP_A;  4'd8: return CAP_Y;  4'd9: return CAP_E;
      4'd10: return CAP_R;
      default: return ASCII_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] status_text(input mode_e m, input logic [3:0] c);
    logic [6:0] ch;
    ch = ASCII_BLANK;
    case (m)
      MODE_PAUSED: begin
        case (c)
          4'd0: ch = CAP_P;  4'd1: ch = CAP_A;  4'd2: ch = CAP_U;
          4'd3: ch = CAP_S;  4'd4: ch = CAP_E;  4'd5: ch = CAP_D;
          default: ch = ASCII_BLANK;
        endcase
      end
      MODE_GAME_OVER: begin
        case (c)
          4'd0: ch = CAP_G;  4'd1: ch = CAP_A;  4'd2: ch = CAP_M;
          4'd3: ch = CAP_E;  4'd5: ch = CAP_O;  4'd6: ch = CAP_V;
          4'd7: ch = CAP_E;  4'd8: ch = CAP_R;
          default: ch = ASCII_BLANK;
        endcase
      end
      MODE_PRESS_START: begin
        case (c)
          4'd0: ch = CAP_P;  4'd1: ch = CAP_R;  4'd2: ch = CAP_E;
          4'd3: ch = CAP_S;  4'd4: ch = CAP_S;  4'd6: ch = CAP_S;
          4'd7: ch = CAP_T;  4'd8: ch = CAP_A;  4'd9: ch = CAP_R;
          4'd10: ch = CAP_T;
          default: ch = ASCII_BLANK;
        endcase
      end
      default: ch = ASCII_BLANK;
    endcase
    return ch;
  endfunction

  // pos 0 is thousands; a digit is leading if it and every digit above are zero.
  function automatic logic [6:0] score_char(input logic [BCD_W-1:0] bcd, input logic [1:0] pos);
    logic [3:0] d;
    logic       lead;
    case (pos)
      2'd0:    begin d = bcd[15:12]; lead = (bcd[15:12] == 4'd0); end
      2'd1:    begin d = bcd[11:8];  lead = (bcd[15:8]  == 8'd0); end
      2'd2:    begin d = bcd[7:4];   lead = (bcd[15:4]  == 12'd0); end
      default: begin d = bcd[3:0];   lead = 1'b0; end
    endcase
    return (BLANK_LEAD != 0 && lead) ? ASCII_BLANK : digit_char(d);
  endfunction

  assign w_line = char_xy[7:4];
  assign w_col  = char_xy[3:0];

  always_comb begin
    w_char = ASCII_BLANK;
    case (w_line)
      4'd0: begin
        if (w_col >= 4'd12)      w_char = score_char(r_disp_red, w_col[1:0]);
        else if (w_col == 4'd11) w_char = ASCII_COLON;
        else                     w_char = red_text(w_col);
      end
      4'd1: begin
        if (w_col >= 4'd12)      w_char = score_char(r_disp_blue, w_col[1:0]);
        else if (w_col == 4'd11) w_char = ASCII_COLON;
        else                     w_char = blue_text(w_col);
      end
      4'd2: begin
        if (!(blink_en && r_phase)) w_char = status_text(mode_e'(mode), w_col);
      end
      default: w_char = ASCII_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_char <= ASCII_BLANK;
    else          r_char <= w_char;
  end

  assign char_code = r_char;
  assign busy      = r_busy;

endmodule

// File: tb/tb_score_text_rom.sv
// Scoreboard bench for score_text_rom: string-based reference model of the
// screen text, queued expectations checked one cycle after each address.
module tb_score_text_rom;

  localparam int unsigned SCORE_W      = 13;
  localparam int unsigned BLINK_FRAMES = 3;
  localparam int unsigned BUSY_CYCLES  = 2 * SCORE_W + 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               frame_tick = 1'b0;
  logic [SCORE_W-1:0] score_red = '0;
  logic [SCORE_W-1:0] score_blue = '0;
  logic [1:0]         mode = 2'd0;
  logic               blink_en = 1'b0;
  logic [7:0]         char_xy = 8'h00;
  logic [6:0]         char_code;
  logic               busy;

  score_text_rom #(
    .SCORE_W(SCORE_W), .BLINK_FRAMES(BLINK_FRAMES), .BLANK_LEAD(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .score_red(score_red), .score_blue(score_blue), .mode(mode),
    .blink_en(blink_en), .char_xy(char_xy), .char_code(char_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: what the screen should currently display.
  int m_red = 0, m_blue = 0, m_ticks = 0;

  typedef struct { logic [7:0] xy; logic [6:0] exp; } exp_t;
  exp_t exp_q[$];
  logic req = 1'b0, req_d;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] model_char(input logic [7:0] xy);
    string line;
    int    ln, col;
    ln  = int'(xy[7:4]);
    col = int'(xy[3:0]);
    line = "";
    if (ln == 0) line = {"RED PLAYER :", $sformatf("%4d", m_red)};
    else if (ln == 1) line = {"BLUE PLAYER:", $sformatf("%4d", m_blue)};
    else if (ln == 2) begin
      if (!(blink_en && ((m_ticks / BLINK_FRAMES) % 2 == 1))) begin
        case (mode)
          2'd1: line = "PAUSED";
          2'd2: line = "GAME OVER";
          2'd3: line = "PRESS START";
          default: line = "";
        endcase
      end
    end
    while (line.len() < 16) line = {line, " "};
    return 7'(line[col]);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) req_d <= 1'b0;
    else          req_d <= req;
  end

  // Monitor: one registered code per issued address, compared in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_d) begin
        if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          check($sformatf("char_xy=%02h", e.xy), int'(char_code), int'(e.exp));
        end
      end
    end
  end

  task automatic ask(input logic [7:0] xy);
    exp_t e;
    @(negedge clk);
    char_xy = xy;
    req = 1'b1;
    e.xy = xy;
    e.exp = model_char(xy);
    exp_q.push_back(e);
  endtask

  task automatic quiet();
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle(input bit check_len);
    int n;
    n = 0;
    while (busy && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check("busy_timeout", n, 0);
    else if (check_len) check("busy_cycles", n, int'(BUSY_CYCLES));
  endtask

  // Accepted tick: scores captured now, displayed once the conversion commits.
  task automatic convert(input int red, input int blue);
    quiet();
    score_red  = SCORE_W'(red);
    score_blue = SCORE_W'(blue);
    frame_tick = 1'b1;
    m_ticks++;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle(1'b1);
    m_red  = red;
    m_blue = blue;
  endtask

  task automatic read_line(input int ln);
    for (int c = 0; c < 16; c++) ask(8'((ln << 4) | c));
  endtask

  task automatic read_scores();
    for (int c = 12; c < 16; c++) ask(8'(c));
    for (int c = 12; c < 16; c++) ask(8'(16 + c));
  endtask

  initial begin
    int bounds[7];
    int r, b;
    bounds = '{0, 8191, 1000, 9, 10, 99, 100};

    #2 reset_n = 1'b0;
    #1;
    check("reset_char_code", int'(char_code), 32'h20);
    check("reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    read_line(0);
    read_line(1);

    convert(205, 7);
    read_scores();

    // Capture happens on the accepted tick only; the tick during busy is ignored.
    quiet();
    score_red  = SCORE_W'(300);
    score_blue = SCORE_W'(11);
    frame_tick = 1'b1;
    m_ticks++;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    score_red = SCORE_W'(99);
    @(negedge clk);
    @(negedge clk);
    check("busy_during_conv", int'(busy), 1);
    frame_tick = 1'b1;
    m_ticks++;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle(1'b0);
    m_red = 300;
    m_blue = 11;
    read_scores();
    convert(99, 11);
    read_scores();

    // Status line across several blink periods, then with blinking disabled.
    mode = 2'd2;
    blink_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      read_line(2);
      convert(m_red, m_blue);
    end
    blink_en = 1'b0;
    read_line(2);
    convert(m_red, m_blue);
    read_line(2);
    mode = 2'd0;
    blink_en = 1'b1;
    read_line(2);

    for (int it = 0; it < 24; it++) begin
      r = (it < 7) ? bounds[it] : int'($urandom_range(0, 8191));
      b = (it < 7) ? bounds[6 - it] : int'($urandom_range(0, 8191));
      quiet();
      mode = 2'($urandom_range(0, 3));
      blink_en = 1'($urandom_range(0, 1));
      convert(r, b);
      read_scores();
      for (int k = 0; k < 6; k++) ask(8'($urandom_range(0, 2) << 4 | $urandom_range(0, 15)));
      ask(8'($urandom_range(3, 15) << 4 | $urandom_range(0, 15)));
    end
    ask(8'h3A);

    convert(8191, 1000);
    read_scores();

    // Asynchronous reset in the middle of a conversion.
    ask(8'h00);
    quiet();
    score_red  = SCORE_W'(1234);
    score_blue = SCORE_W'(4321);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_char", int'(char_code), 32'h20);
    m_red = 0;
    m_blue = 0;
    m_ticks = 0;
    @(negedge clk);
    reset_n = 1'b1;
    read_scores();
    read_line(2);
    convert(8191, 1000);
    read_scores();
    quiet();
    quiet();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
